// File: rtl/reg_file_dumper.sv
// Debug dumper: walks a spare register-file read port and streams each
// (index, data) pair over valid/ready while accumulating a checksum.
module reg_file_dumper #(
    parameter int unsigned NREG    = 32,
    parameter int unsigned AW      = 5,
    parameter int unsigned DW      = 32,
    parameter int unsigned SKIP_X0 = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] ra,
    input  logic [DW-1:0] rd,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_idx,
    output logic [DW-1:0] out_data,
    output logic [DW-1:0] checksum
);

    typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

    localparam logic [AW-1:0] LAST  = AW'(NREG - 1);
    localparam logic [AW-1:0] FIRST = (SKIP_X0 != 0) ? AW'(1) : AW'(0);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          out_valid_q, out_valid_d;
    logic [AW-1:0] out_idx_q, out_idx_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic [DW-1:0] checksum_q, checksum_d;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_data_d  = out_data_q;
        checksum_d  = checksum_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d     = FIRST;
                    checksum_d = '0;
                    busy_d     = 1'b1;
                    state_d    = READ;
                end
            end
            READ: begin
                out_data_d  = rd;
                out_idx_d   = addr_q;
                checksum_d  = checksum_q + rd;
                out_valid_d = 1'b1;
                state_d     = SEND;
            end
            SEND: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    // Stop at the last register; the address never wraps.
                    if (addr_q == LAST) begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
            checksum_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
            checksum_q  <= checksum_d;
        end
    end

    assign ra        = addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_data  = out_data_q;
    assign checksum  = checksum_q;

endmodule

// File: tb/tb_reg_file_dumper.sv
// Scoreboard bench for reg_file_dumper: two instances (SKIP_X0=0/1) share a
// modelled register file; expected words are queued, a monitor pops on handshake.
module tb_reg_file_dumper;

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        out_ready = 1'b1;
    logic        start_s   [2];
    logic        busy_s    [2];
    logic        done_s    [2];
    logic [4:0]  ra_s      [2];
    logic [31:0] rd_s      [2];
    logic        valid_s   [2];
    logic [4:0]  idx_s     [2];
    logic [31:0] data_s    [2];
    logic [31:0] ck_s      [2];
    logic [31:0] regs      [32];

    exp_t sbq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    always_comb begin
        rd_s[0] = regs[ra_s[0]];
        rd_s[1] = regs[ra_s[1]];
    end

    reg_file_dumper #(.NREG(32), .AW(5), .DW(32), .SKIP_X0(0)) u0 (
        .clk(clk), .rst(rst), .start(start_s[0]), .busy(busy_s[0]), .done(done_s[0]),
        .ra(ra_s[0]), .rd(rd_s[0]), .out_valid(valid_s[0]), .out_ready(out_ready),
        .out_idx(idx_s[0]), .out_data(data_s[0]), .checksum(ck_s[0])
    );

    reg_file_dumper #(.NREG(32), .AW(5), .DW(32), .SKIP_X0(1)) u1 (
        .clk(clk), .rst(rst), .start(start_s[1]), .busy(busy_s[1]), .done(done_s[1]),
        .ra(ra_s[1]), .rd(rd_s[1]), .out_valid(valid_s[1]), .out_ready(out_ready),
        .out_idx(idx_s[1]), .out_data(data_s[1]), .checksum(ck_s[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: a handshake completes at the next rising edge when valid & ready & !rst.
    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (!rst && out_ready && valid_s[s]) begin
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_word: inst %0d idx %0d data 0x%0h, expected none",
                             s, idx_s[s], data_s[s]);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("word_idx", 32'(idx_s[s]), 32'(e.idx));
                    chk("word_data", data_s[s], e.data);
                end
            end
        end
    end

    // One dump on instance s. bp/st/rs >= 0 select backpressure, mid-dump start
    // and mid-dump reset at that register index. Cycle 1 is the first READ cycle.
    task automatic dump(input int s, input int bp, input int st, input int rs,
                        input logic [31:0] ck, input int dcyc);
        int   c, dones, dcy;
        bit   bp_done, st_done;
        exp_t e;
        for (int k = (s == 1) ? 1 : 0; k < 32; k++) begin
            e.idx  = 5'(k);
            e.data = regs[k];
            sbq.push_back(e);
        end
        @(posedge clk); #1 start_s[s] = 1'b1;
        @(posedge clk); #1 start_s[s] = 1'b0;
        c = 0; dones = 0; dcy = 0; bp_done = 0; st_done = 0;
        while (c < 300) begin
            @(negedge clk); c++;
            if (done_s[s]) begin dones++; dcy = c; end
            if (dones > 0 && !busy_s[s]) break;
            if (rs >= 0 && busy_s[s] && !valid_s[s] && ra_s[s] == 5'(rs)) begin
                rst = 1'b1;
                @(posedge clk); #1 rst = 1'b0;
                @(negedge clk);
                chk("rst_busy", 32'(busy_s[s]), 0);
                chk("rst_done", 32'(done_s[s]), 0);
                chk("rst_valid", 32'(valid_s[s]), 0);
                chk("rst_idx", 32'(idx_s[s]), 0);
                chk("rst_data", data_s[s], 0);
                chk("rst_checksum", ck_s[s], 0);
                chk("rst_ra", 32'(ra_s[s]), 0);
                chk("rst_no_done", 32'(dones), 0);
                chk("rst_words_left", 32'(sbq.size()), 32'(32 - rs));
                sbq.delete();
                return;
            end
            if (bp >= 0 && !bp_done && busy_s[s] && !valid_s[s] && ra_s[s] == 5'(bp)) begin
                bp_done = 1;
                @(posedge clk); #1 out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk); c++;
                    chk("bp_valid", 32'(valid_s[s]), 1);
                    chk("bp_idx", 32'(idx_s[s]), 32'(bp));
                    chk("bp_data", data_s[s], regs[bp]);
                    chk("bp_ra", 32'(ra_s[s]), 32'(bp));
                end
                @(posedge clk); #1 out_ready = 1'b1;
                @(negedge clk); c++;
                @(negedge clk); c++;
                chk("bp_next_read_ra", 32'(ra_s[s]), 32'(bp + 1));
                chk("bp_next_read_valid", 32'(valid_s[s]), 0);
                @(negedge clk); c++;
                chk("bp_next_valid", 32'(valid_s[s]), 1);
                chk("bp_next_idx", 32'(idx_s[s]), 32'(bp + 1));
            end
            if (st >= 0 && !st_done && valid_s[s] && idx_s[s] == 5'(st)) begin
                st_done = 1;
                start_s[s] = 1'b1;
                @(posedge clk); #1 start_s[s] = 1'b0;
            end
        end
        if (c >= 300) begin
            n_vec++;
            n_bad++;
            $display("FAIL dump_timeout: inst %0d busy %0d after %0d cycles, expected done", s, busy_s[s], c);
        end
        chk("done_count", 32'(dones), 1);
        chk("done_cycle", 32'(dcy), 32'(dcyc));
        chk("checksum", ck_s[s], ck);
        chk("sb_empty", 32'(sbq.size()), 0);
    endtask

    initial begin
        start_s[0] = 1'b1;
        start_s[1] = 1'b1;
        for (int k = 0; k < 32; k++) regs[k] = (k == 0) ? 32'h0 : 32'h100 + 32'(k);

        // Reset held with start asserted: everything stays at reset values.
        repeat (12) begin
            @(negedge clk);
            chk("reset_busy", 32'(busy_s[0]), 0);
            chk("reset_valid", 32'(valid_s[0]), 0);
            chk("reset_checksum", ck_s[0], 0);
            chk("reset_ra", 32'(ra_s[0]), 0);
            chk("reset_busy_skip", 32'(busy_s[1]), 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        repeat (2) @(posedge clk);

        // 0x100*31 + (1+..+31) = 0x1F00 + 0x1F0 = 0x20F0
        dump(0, -1, -1, -1, 32'h0000_20F0, 65);
        dump(0,  3, -1, -1, 32'h0000_20F0, 70);
        dump(1, -1, -1, -1, 32'h0000_20F0, 63);
        dump(0, -1, 10, -1, 32'h0000_20F0, 65);
        dump(0, -1, -1, 20, 32'h0000_20F0, 65);
        dump(0, -1, -1, -1, 32'h0000_20F0, 65);

        for (int k = 1; k < 32; k++) regs[k] = 32'hFFFF_FFFF;
        dump(0, -1, -1, -1, 32'hFFFF_FFE1, 65);

        repeat (3) @(negedge clk);
        chk("idle_checksum_hold", ck_s[0], 32'hFFFF_FFE1);
        chk("idle_busy", 32'(busy_s[0]), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
